// File: rtl/demux_4lane.sv
// demux_4lane: de-interleaves a 4-slot byte stream into four registered lanes; DEMUX_ERR_CNT_EN adds err_count.
module demux_4lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_000,
  input  logic              valid_000,
  input  logic              frame_start,
  output logic [DATA_W-1:0] data_0,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  output logic [DATA_W-1:0] data_3,
  output logic              valid_0,
  output logic              valid_1,
  output logic              valid_2,
  output logic              valid_3,
  output logic              out_strobe,
  output logic              synced,
`ifdef DEMUX_ERR_CNT_EN
  output logic [7:0]        err_count,
`endif
  output logic              align_err
);
  localparam logic [0:0] UNSYNC = 1'b0;
  localparam logic [0:0] SYNC   = 1'b1;
  logic [0:0] state;
  logic [1:0] cnt;
  logic [1:0] slot;
  logic [3:0][DATA_W-1:0] st_d, w_d;
  logic [3:0] st_v, w_v;
  logic take, misalign, done;
  assign synced = (state == SYNC);
  // A frame_start outside slot 0 (or while unsynced) restarts the frame at lane 0
  always_comb begin
    misalign = synced && frame_start && (cnt != 2'd0);
    take = synced || frame_start;
    slot = (misalign || !synced) ? 2'd0 : cnt;
    done = synced && !misalign && (cnt == 2'd3);
    w_d = st_d;
    w_v = st_v;
    w_v[slot] = take ? valid_000 : st_v[slot];
    w_d[slot] = (take && valid_000) ? data_000 : st_d[slot];
  end
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state <= UNSYNC;
      cnt <= 2'd0;
      st_d <= '0;
      st_v <= '0;
      {data_0, data_1, data_2, data_3} <= '0;
      {valid_0, valid_1, valid_2, valid_3} <= '0;
      out_strobe <= 1'b0;
      align_err <= 1'b0;
    end else begin
      state <= take ? SYNC : state;
      cnt <= take ? slot + 2'd1 : cnt;
      st_d <= w_d;
      st_v <= w_v;
      out_strobe <= done;
      align_err <= misalign;
      if (done) begin
        {data_3, data_2, data_1, data_0} <= w_d;
        {valid_3, valid_2, valid_1, valid_0} <= w_v;
      end
    end
  end
`ifdef DEMUX_ERR_CNT_EN
  always_ff @(posedge clk_4f) begin
    if (reset) err_count <= 8'd0;
    else if (misalign) err_count <= err_count + {7'd0, err_count != 8'hFF};
  end
`endif
endmodule

// File: tb/tb_demux_4lane.sv
// tb_demux_4lane: randomized and directed checks of demux_4lane against a frame-level reference model.
module tb_demux_4lane;
  logic clk_4f = 0;
  logic reset = 1;
  logic [7:0] data_000 = 0;
  logic valid_000 = 0;
  logic frame_start = 0;
  logic [7:0] data_0, data_1, data_2, data_3;
  logic valid_0, valid_1, valid_2, valid_3;
  logic out_strobe, synced, align_err;
  logic [7:0] err_count;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk_4f = ~clk_4f;

  demux_4lane #(.DATA_W(8)) dut (
    .clk_4f(clk_4f), .reset(reset), .data_000(data_000), .valid_000(valid_000),
    .frame_start(frame_start), .data_0(data_0), .data_1(data_1), .data_2(data_2),
    .data_3(data_3), .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2),
    .valid_3(valid_3), .out_strobe(out_strobe), .synced(synced),
`ifdef DEMUX_ERR_CNT_EN
    .err_count(err_count),
`endif
    .align_err(align_err)
  );
`ifndef DEMUX_ERR_CNT_EN
  assign err_count = 8'd0;
`endif

  // Reference: position within the frame (-1 = not aligned), last byte seen per lane, published frame
  int m_pos = -1;
  logic [7:0] m_last [4];
  logic m_lv [4];
  logic [7:0] m_d [4];
  logic m_v [4];
  logic m_stb = 0, m_err = 0;
  int m_errs = 0;
  logic [38:0] obs, exp_v;
  assign obs = {data_3, data_2, data_1, data_0, valid_3, valid_2, valid_1, valid_0, out_strobe, synced, align_err};
  assign exp_v = {m_d[3], m_d[2], m_d[1], m_d[0], m_v[3], m_v[2], m_v[1], m_v[0], m_stb, m_pos >= 0, m_err};

  task automatic model(input logic r, input logic fs, input logic v, input logic [7:0] d);
    int lane;
    m_stb = 0;
    m_err = 0;
    if (r) begin
      m_pos = -1;
      m_errs = 0;
      for (int i = 0; i < 4; i++) begin m_last[i] = 0; m_lv[i] = 0; m_d[i] = 0; m_v[i] = 0; end
      return;
    end
    if (m_pos < 0 && !fs) return;
    if (m_pos > 0 && fs) begin m_err = 1; m_errs = m_errs + 1; end
    lane = fs ? 0 : m_pos;
    m_lv[lane] = v;
    if (v) m_last[lane] = d;
    if (lane == 3) begin
      m_stb = 1;
      for (int i = 0; i < 4; i++) begin m_d[i] = m_last[i]; m_v[i] = m_lv[i]; end
    end
    m_pos = (lane + 1) % 4;
  endtask

  task automatic cycle(input logic r, input logic fs, input logic v, input logic [7:0] d);
    reset = r; frame_start = fs; valid_000 = v; data_000 = d;
    @(posedge clk_4f);
    model(r, fs, v, d);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 1, 8'h55);
    cycle(1, 0, 0, 0);
    total++;
    if (obs !== 39'd0 || err_count !== 8'd0) begin
      bad++; $display("FAIL reset obs=%h err_count=%0d required all zero", obs, err_count);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      cycle(0, i == 0, 1, 8'hA0 + 8'(i));
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL basic_slot%0d obs=%h exp=%h", i, obs, exp_v); end
    end
    total++;
    if ({data_3, data_2, data_1, data_0} !== 32'hA3A2A1A0 || {valid_3, valid_2, valid_1, valid_0} !== 4'hF
        || out_strobe !== 1 || synced !== 1) begin
      bad++; $display("FAIL basic_frame data=%h%h%h%h valid=%b%b%b%b strobe=%b synced=%b required A3A2A1A0 1111 1 1",
        data_3, data_2, data_1, data_0, valid_3, valid_2, valid_1, valid_0, out_strobe, synced);
    end
  endtask

  task automatic test_continuous();
    int strobes = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(0, (i % 4) == 0, 1, 8'h10 * 8'(i / 4 + 1) + 8'(i % 4));
      strobes += out_strobe;
      total++;
      if (obs !== exp_v || align_err !== 0) begin bad++; $display("FAIL continuous_%0d obs=%h exp=%h", i, obs, exp_v); end
    end
    total++;
    if (strobes != 2 || {data_3, data_2, data_1, data_0} !== 32'h23222120) begin
      bad++; $display("FAIL continuous_count strobes=%0d data=%h%h%h%h required 2 23222120", strobes, data_3, data_2, data_1, data_0);
    end
  endtask

  task automatic test_invalid_slot();
    for (int i = 0; i < 4; i++) begin
      cycle(0, i == 0, i != 2, i == 2 ? 8'h99 : 8'h30 + 8'(i));
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL invalid_slot_%0d obs=%h exp=%h", i, obs, exp_v); end
    end
    total++;
    if ({data_3, data_2, data_1, data_0} !== 32'h33223130 || {valid_3, valid_2, valid_1, valid_0} !== 4'b1011) begin
      bad++; $display("FAIL invalid_slot_frame data=%h%h%h%h valid=%b%b%b%b required 33223130 1011",
        data_3, data_2, data_1, data_0, valid_3, valid_2, valid_1, valid_0);
    end
  endtask

  task automatic test_misalign();
    int strobe_at;
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 8'h40);
    cycle(0, 0, 1, 8'h41);
    cycle(0, 1, 1, 8'h50);
    total++;
    if (align_err !== 1 || out_strobe !== 0 || obs !== exp_v) begin
      bad++; $display("FAIL misalign_pulse align_err=%b strobe=%b required 1 0", align_err, out_strobe);
    end
    strobe_at = 0;
    for (int i = 1; i < 6; i++) begin
      cycle(0, 0, 1, 8'h50 + 8'(i));
      if (out_strobe && strobe_at == 0) strobe_at = i + 1;
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL misalign_%0d obs=%h exp=%h", i, obs, exp_v); end
    end
    total++;
    if (strobe_at != 4 || data_0 !== 8'h50) begin
      bad++; $display("FAIL misalign_strobe strobe_after=%0d data_0=%h required 4 50", strobe_at, data_0);
    end
`ifdef DEMUX_ERR_CNT_EN
    total++;
    if (err_count !== 8'd1) begin bad++; $display("FAIL misalign_err_count got=%0d required 1", err_count); end
`endif
  endtask

  task automatic test_reset_mid();
    cycle(0, 1, 1, 8'h60);
    cycle(0, 0, 1, 8'h61);
    cycle(1, 0, 1, 8'h62);
    total++;
    if (obs !== 39'd0 || err_count !== 8'd0) begin bad++; $display("FAIL reset_mid obs=%h required 0", obs); end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 8'h70 + 8'(i));
      total++;
      if (out_strobe !== 0 || synced !== 0 || obs !== exp_v) begin
        bad++; $display("FAIL reset_mid_nofs_%0d strobe=%b synced=%b required 0 0", i, out_strobe, synced);
      end
    end
  endtask

  task automatic test_saturate();
    int pulses = 0;
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 8'h01);
    for (int i = 0; i < 300; i++) begin
      cycle(0, 1, 1, 8'(i));
      pulses += align_err;
    end
    total++;
    if (pulses != 300 || obs !== exp_v) begin bad++; $display("FAIL saturate_pulses got=%0d required 300", pulses); end
`ifdef DEMUX_ERR_CNT_EN
    total++;
    if (err_count !== 8'd255 || m_errs != 300) begin bad++; $display("FAIL saturate_err_count got=%0d required 255", err_count); end
`endif
  endtask

  task automatic test_random();
    int last = -100;
    int k = 0;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic r, fs;
      r = ($urandom_range(0, 299) == 0);
      fs = (k % 4 == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 39) == 0);
      k = fs ? 1 : k + 1;
      cycle(r, fs, $urandom_range(0, 3) != 0, 8'($urandom));
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL random_%0d obs=%h exp=%h", i, obs, exp_v); end
`ifdef DEMUX_ERR_CNT_EN
      total++;
      if (err_count !== 8'(m_errs > 255 ? 255 : m_errs)) begin bad++; $display("FAIL random_err_count_%0d got=%0d exp=%0d", i, err_count, m_errs); end
`endif
      if (out_strobe) begin
        total++;
        if (cyc - last < 4) begin bad++; $display("FAIL strobe_spacing gap=%0d required >=4", cyc - last); end
        last = cyc;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_continuous();
    test_invalid_slot();
    test_misalign();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
